// File: rtl/mult_ctrl.sv
// Sequencer for an iterative multiplier that shares the execute-stage ALU.
// Clears the multiplier, lends it the ALU while running, and captures HI/LO.
module mult_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        MultE,
  input  logic        FlushE,
  input  logic [31:0] PipeA,
  input  logic [31:0] PipeB,
  input  logic [31:0] MulA,
  input  logic [31:0] MulB,
  input  logic        MulDone,
  input  logic [31:0] MulHi,
  input  logic [31:0] MulLo,
  output logic [31:0] ALUSrcA,
  output logic [31:0] ALUSrcB,
  output logic        MulStart,
  output logic        MulRst,
  output logic        StallMult,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        MulErr,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, CLR = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [5:0] CNT_MAX = 6'd40;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] cnt;
  logic       take_result;
  logic       abort;
  logic       timeout;

  assign state_dbg = state;
  assign ALUSrcA   = (state == RUN) ? MulA : PipeA;
  assign ALUSrcB   = (state == RUN) ? MulB : PipeB;

  always_comb begin
    state_nxt   = state;
    take_result = 1'b0;
    abort       = 1'b0;
    timeout     = 1'b0;
    MulStart    = 1'b0;
    StallMult   = 1'b0;
    case (state)
      IDLE: begin
        if (MultE && !FlushE) begin
          StallMult = 1'b1;
          state_nxt = CLR;
        end
      end
      CLR: begin
        StallMult = 1'b1;
        state_nxt = FlushE ? IDLE : RUN;
      end
      RUN: begin
        StallMult = 1'b1;
        MulStart  = 1'b1;
        // A flush beats a completion arriving in the same cycle.
        if (FlushE) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (MulDone) begin
          take_result = 1'b1;
          state_nxt   = DONE;
        end else if (cnt == CNT_MAX) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        // The instruction that started us is still in execute; ignore MultE.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      MulErr <= 1'b0;
      MulRst <= 1'b1;
    end else begin
      state  <= state_nxt;
      MulRst <= (state_nxt == CLR) || abort || timeout;
      // cnt counts completed RUN cycles; the RUN cycle that sees 40 times out.
      if (state == CLR) begin
        cnt <= 6'd0;
      end else if ((state == RUN) && (cnt != CNT_MAX)) begin
        cnt <= cnt + 6'd1;
      end
      if (take_result) begin
        hi <= MulHi;
        lo <= MulLo;
      end
      if (timeout) begin
        MulErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl with a behavioural iterative multiplier
// and a queue of expected HI/LO pairs checked whenever DONE is reached.
module tb_mult_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLR  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MultE = 1'b0;
  logic        FlushE = 1'b0;
  logic [31:0] PipeA = 32'd0;
  logic [31:0] PipeB = 32'd0;
  logic [31:0] MulA = 32'd0;
  logic [31:0] MulB = 32'd0;
  logic        MulDone;
  logic [31:0] MulHi;
  logic [31:0] MulLo;
  logic [31:0] ALUSrcA;
  logic [31:0] ALUSrcB;
  logic        MulStart;
  logic        MulRst;
  logic        StallMult;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        MulErr;
  logic [1:0]  state_dbg;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_hilo = 64'd0;

  // multiplier model knobs
  int          lat = 8;
  logic        never_done = 1'b0;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  mult_ctrl dut (
    .clk(clk), .rst(rst), .MultE(MultE), .FlushE(FlushE),
    .PipeA(PipeA), .PipeB(PipeB), .MulA(MulA), .MulB(MulB),
    .MulDone(MulDone), .MulHi(MulHi), .MulLo(MulLo),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MulStart(MulStart),
    .MulRst(MulRst), .StallMult(StallMult), .hi(hi), .lo(lo),
    .MulErr(MulErr), .state_dbg(state_dbg)
  );

  // Iterative multiplier: finishes after lat enabled cycles, result sticky until MulRst.
  always @(posedge clk) begin
    if (MulRst) begin
      MulDone <= 1'b0;
      MulHi   <= 32'd0;
      MulLo   <= 32'd0;
      m_cnt   <= 0;
    end else if (MulStart && !MulDone && !never_done) begin
      if (m_cnt == lat - 1) begin
        MulDone        <= 1'b1;
        {MulHi, MulLo} <= {32'd0, ALUSrcA} * {32'd0, ALUSrcB};
      end
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a multiply and follow it to DONE; cyc is the edge count from MultE to DONE.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input bit hold, output int cyc);
    MulA   = a;
    MulB   = b;
    PipeA  = $urandom;
    PipeB  = $urandom;
    MultE  = 1'b1;
    FlushE = 1'b0;
    exp_q.push_back({32'd0, a} * {32'd0, b});
    #1;
    chk("stall_issue", StallMult, 1);
    cyc = 0;
    while (state_dbg != S_DONE && cyc < 200) begin
      tick();
      cyc++;
      if (state_dbg == S_RUN) begin
        chk("alu_a_run", ALUSrcA, a);
        chk("alu_b_run", ALUSrcB, b);
      end else begin
        chk("alu_a_pipe", ALUSrcA, PipeA);
      end
      if (state_dbg != S_DONE) chk("stall_busy", StallMult, 1);
    end
    if (state_dbg != S_DONE) begin
      chk("done_reached", 0, 1);
      return;
    end
    last_hilo = exp_q.pop_front();
    chk("hi_done", hi, last_hilo[63:32]);
    chk("lo_done", lo, last_hilo[31:0]);
    chk("stall_done", StallMult, 0);
    chk("start_done", MulStart, 0);
    if (!hold) MultE = 1'b0;
  endtask

  task automatic enter_run();
    MultE = 1'b1;
    tick();
    chk("st_clr", state_dbg, S_CLR);
    chk("rst_clr", MulRst, 1);
    chk("start_clr", MulStart, 0);
    tick();
    chk("st_run", state_dbg, S_RUN);
  endtask

  initial begin
    int cyc;
    int cyc2;
    int nrun;

    // reset
    tick();
    tick();
    chk("rst_state", state_dbg, S_IDLE);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_err", MulErr, 0);
    chk("rst_mulrst", MulRst, 1);
    rst   = 1'b0;
    PipeA = 32'h1234_5678;
    PipeB = 32'h9abc_def0;
    MultE = 1'b1;
    #1;
    chk("post_rst_stall", StallMult, 1);
    chk("post_rst_alu_a", ALUSrcA, 32'h1234_5678);
    chk("post_rst_alu_b", ALUSrcB, 32'h9abc_def0);
    chk("post_rst_start", MulStart, 0);
    FlushE = 1'b1;
    #1;
    chk("flush_idle_stall", StallMult, 0);
    MultE  = 1'b0;
    FlushE = 1'b0;
    tick();
    chk("idle_stay", state_dbg, S_IDLE);
    chk("idle_mulrst", MulRst, 0);

    // basic and overflow products; fixed latency lat+3 edges
    run_mult(32'd7, 32'd6, 0, cyc);
    chk("basic_cycles", cyc, lat + 3);
    tick();
    run_mult(32'hFFFF_FFFF, 32'd2, 0, cyc);
    chk("ovf_cycles", cyc, lat + 3);
    tick();
    run_mult(32'hFFFF_FFFF, 32'd2, 0, cyc2);
    chk("ovf_cycles_rpt", cyc2, lat + 3);
    tick();

    // back-to-back with MultE held through DONE
    run_mult(32'd3, 32'd5, 1, cyc);
    MulA = 32'd4;
    MulB = 32'd4;
    tick();
    chk("b2b_no_restart", state_dbg, S_IDLE);
    chk("b2b_stall", StallMult, 1);
    run_mult(32'd4, 32'd4, 0, cyc);
    chk("b2b_cycles", cyc, lat + 3);
    tick();

    // abort on the 10th RUN cycle
    lat  = 16;
    MulA = 32'd9;
    MulB = 32'd9;
    enter_run();
    for (int i = 0; i < 9; i++) tick();
    chk("abort_pre_state", state_dbg, S_RUN);
    FlushE = 1'b1;
    MultE  = 1'b0;
    tick();
    FlushE = 1'b0;
    chk("abort_state", state_dbg, S_IDLE);
    chk("abort_mulrst", MulRst, 1);
    chk("abort_stall", StallMult, 0);
    chk("abort_hilo", {hi, lo}, last_hilo);
    tick();
    chk("abort_mulrst_drop", MulRst, 0);

    // flush coinciding with completion
    lat = 8;
    MulA = 32'd11;
    MulB = 32'd13;
    enter_run();
    for (int i = 0; i < lat; i++) tick();
    chk("coinc_done_seen", MulDone, 1);
    FlushE = 1'b1;
    MultE  = 1'b0;
    tick();
    FlushE = 1'b0;
    chk("coinc_state", state_dbg, S_IDLE);
    chk("coinc_hilo", {hi, lo}, last_hilo);
    tick();

    // flush during CLR
    MultE = 1'b1;
    tick();
    chk("clrflush_pre", state_dbg, S_CLR);
    FlushE = 1'b1;
    #1;
    chk("clrflush_mulrst", MulRst, 1);
    tick();
    MultE  = 1'b0;
    FlushE = 1'b0;
    chk("clrflush_state", state_dbg, S_IDLE);
    tick();

    // timeout with the multiplier never finishing
    never_done = 1'b1;
    enter_run();
    MultE = 1'b0;
    nrun = 0;
    while (state_dbg == S_RUN && nrun < 100) begin
      tick();
      nrun++;
    end
    chk("to_run_cycles", nrun, 41);
    chk("to_state", state_dbg, S_IDLE);
    chk("to_err", MulErr, 1);
    chk("to_mulrst", MulRst, 1);
    chk("to_hilo", {hi, lo}, last_hilo);
    for (int i = 0; i < 5; i++) tick();
    chk("to_err_sticky", MulErr, 1);
    never_done = 1'b0;

    // reset on the 20th RUN cycle
    lat = 30;
    enter_run();
    for (int i = 0; i < 19; i++) tick();
    chk("midrst_pre", state_dbg, S_RUN);
    rst   = 1'b1;
    MultE = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_state", state_dbg, S_IDLE);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_err", MulErr, 0);
    chk("midrst_stall", StallMult, 0);
    chk("midrst_mulrst", MulRst, 1);
    tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
